// File: rtl/ariane_regfile.sv
// Flop-based integer register file with combinational read ports and clocked write ports.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data onto matching read ports.
module ariane_regfile #(
    parameter int unsigned NR_READ_PORTS  = 2,
    parameter int unsigned NR_WRITE_PORTS = 2,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ZERO_REG_ZERO  = 1
) (
    input  logic                                         clk_i,
    input  logic                                         rst_i,
    input  logic                                         test_en_i,
    input  logic [NR_READ_PORTS-1:0][4:0]                raddr_i,
    output logic [NR_READ_PORTS-1:0][DATA_WIDTH-1:0]     rdata_o,
    input  logic [NR_WRITE_PORTS-1:0][4:0]               waddr_i,
    input  logic [NR_WRITE_PORTS-1:0][DATA_WIDTH-1:0]    wdata_i,
    input  logic [NR_WRITE_PORTS-1:0]                    we_i
);

    localparam int unsigned NUM_WORDS = 32;

    logic [NUM_WORDS-1:0][DATA_WIDTH-1:0] mem_q;
    logic [NUM_WORDS-1:0][DATA_WIDTH-1:0] mem_d;

    // Flops are never clock-gated here, so the DFT gate-disable has nothing to act on.
    logic unused_test_en;
    assign unused_test_en = test_en_i;

    // Ports are applied in ascending order so the highest-index port wins a conflict.
    always_comb begin
        mem_d = mem_q;
        for (int p = 0; p < int'(NR_WRITE_PORTS); p++) begin
            if (we_i[p]) begin
                mem_d[waddr_i[p]] = wdata_i[p];
            end
        end
        if (ZERO_REG_ZERO != 0) begin
            mem_d[0] = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    always_comb begin
        rdata_o = '0;
        for (int r = 0; r < int'(NR_READ_PORTS); r++) begin
            if ((ZERO_REG_ZERO != 0) && (raddr_i[r] == 5'd0)) begin
                rdata_o[r] = '0;
            end else begin
                rdata_o[r] = mem_q[raddr_i[r]];
`ifdef REGFILE_BYPASS_EN
                // Later ports overwrite earlier matches, mirroring the write-conflict rule.
                for (int p = 0; p < int'(NR_WRITE_PORTS); p++) begin
                    if (!rst_i && we_i[p] && (waddr_i[p] == raddr_i[r])) begin
                        rdata_o[r] = wdata_i[p];
                    end
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_ariane_regfile.sv
// Bench for ariane_regfile: directed cases plus randomized traffic against an array model,
// covering both the hardwired-x0 and ordinary-x0 configurations side by side.
module tb_ariane_regfile;

    localparam int NR = 2;
    localparam int NW = 2;
    localparam int DW = 32;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    test_en = 1'b0;
    logic [NR-1:0][4:0]      raddr = '0;
    logic [NW-1:0][4:0]      waddr = '0;
    logic [NW-1:0][DW-1:0]   wdata = '0;
    logic [NW-1:0]           we = '0;
    logic [NR-1:0][DW-1:0]   rdata_z;
    logic [NR-1:0][DW-1:0]   rdata_nz;

    ariane_regfile #(
        .NR_READ_PORTS(NR), .NR_WRITE_PORTS(NW), .DATA_WIDTH(DW), .ZERO_REG_ZERO(1)
    ) dut (
        .clk_i(clk), .rst_i(rst), .test_en_i(test_en),
        .raddr_i(raddr), .rdata_o(rdata_z),
        .waddr_i(waddr), .wdata_i(wdata), .we_i(we)
    );

    ariane_regfile #(
        .NR_READ_PORTS(NR), .NR_WRITE_PORTS(NW), .DATA_WIDTH(DW), .ZERO_REG_ZERO(0)
    ) dut_nz (
        .clk_i(clk), .rst_i(rst), .test_en_i(test_en),
        .raddr_i(raddr), .rdata_o(rdata_nz),
        .waddr_i(waddr), .wdata_i(wdata), .we_i(we)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] ref_z[32];
    logic [DW-1:0] ref_nz[32];

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Architectural view: a register holds the last value written to it.
    function automatic logic [DW-1:0] model_read(input bit zero, input logic [4:0] a);
        if (zero) return (a == 5'd0) ? '0 : ref_z[a];
        return ref_nz[a];
    endfunction

    // Value a read should see right now, with the current (not yet clocked) write inputs.
    function automatic logic [DW-1:0] model_now(input bit zero, input logic [4:0] a);
`ifdef REGFILE_BYPASS_EN
        if (!rst && !(zero && a == 5'd0)) begin
            for (int p = NW - 1; p >= 0; p--) begin
                if (we[p] && waddr[p] == a) return wdata[p];
            end
        end
`endif
        return model_read(zero, a);
    endfunction

    task automatic model_edge();
        if (rst) begin
            for (int a = 0; a < 32; a++) begin
                ref_z[a] = '0;
                ref_nz[a] = '0;
            end
        end else begin
            for (int a = 0; a < 32; a++) begin
                for (int p = NW - 1; p >= 0; p--) begin
                    if (we[p] && waddr[p] == 5'(a)) begin
                        ref_nz[a] = wdata[p];
                        if (a != 0) ref_z[a] = wdata[p];
                        break;
                    end
                end
            end
        end
    endtask

    // driver tasks
    task automatic clock_edge();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic write2(input logic [1:0] en, input logic [4:0] a0, input logic [DW-1:0] d0,
                          input logic [4:0] a1, input logic [DW-1:0] d1);
        we = en;
        waddr[0] = a0; wdata[0] = d0;
        waddr[1] = a1; wdata[1] = d1;
        clock_edge();
        we = '0;
    endtask

    task automatic read_const(input string tag, input logic [4:0] r0, input logic [4:0] r1,
                              input logic [DW-1:0] e0, input logic [DW-1:0] e1);
        raddr[0] = r0;
        raddr[1] = r1;
        #1;
        exp_q.push_back(e0); check($sformatf("%s_z0", tag), rdata_z[0], exp_q.pop_front());
        exp_q.push_back(e1); check($sformatf("%s_z1", tag), rdata_z[1], exp_q.pop_front());
        exp_q.push_back(e0); check($sformatf("%s_nz0", tag), rdata_nz[0], exp_q.pop_front());
        exp_q.push_back(e1); check($sformatf("%s_nz1", tag), rdata_nz[1], exp_q.pop_front());
    endtask

    task automatic read_model(input string tag, input logic [4:0] r0, input logic [4:0] r1);
        raddr[0] = r0;
        raddr[1] = r1;
        #1;
        for (int r = 0; r < NR; r++) begin
            exp_q.push_back(model_now(1'b1, raddr[r]));
            check($sformatf("%s_z%0d a=%0d", tag, r, raddr[r]), rdata_z[r], exp_q.pop_front());
            exp_q.push_back(model_now(1'b0, raddr[r]));
            check($sformatf("%s_nz%0d a=%0d", tag, r, raddr[r]), rdata_nz[r], exp_q.pop_front());
        end
    endtask

    initial begin
        for (int a = 0; a < 32; a++) begin
            ref_z[a] = $urandom;
            ref_nz[a] = $urandom;
        end
        rst = 1'b1;
        clock_edge();
        clock_edge();
        rst = 1'b0;
        for (int i = 0; i < 16; i++) read_const("reset", 5'(i), 5'(31 - i), '0, '0);

        write2(2'b11, 5'd1, 32'd924232, 5'd2, 32'd3432);
        read_const("dual", 5'd1, 5'd2, 32'd924232, 32'd3432);
        write2(2'b11, 5'd13, 32'd100, 5'd14, 32'd200);
        read_const("pair2", 5'd13, 5'd14, 32'd100, 32'd200);
        read_const("keep", 5'd1, 5'd2, 32'd924232, 32'd3432);
        write2(2'b11, 5'd5, 32'd1000, 5'd5, 32'd1234);
        read_const("conflict", 5'd5, 5'd5, 32'd1234, 32'd1234);

        write2(2'b11, 5'd0, 32'hDEAD, 5'd0, 32'hDEAD);
        raddr = '0;
        #1;
        check("x0_zero", rdata_z[0], 32'd0);
        check("x0_zero_p1", rdata_z[1], 32'd0);
        check("x0_plain", rdata_nz[0], 32'hDEAD);

        write2(2'b00, 5'd1, 32'h1111, 5'd2, 32'h2222);
        read_const("gate", 5'd1, 5'd2, 32'd924232, 32'd3432);

        we = 2'b01; waddr[0] = 5'd7; wdata[0] = 32'd55;
        rst = 1'b1;
        clock_edge();
        rst = 1'b0; we = '0;
        read_const("rst_prio", 5'd7, 5'd1, '0, '0);

        // Same-cycle write and read of x9, checked before the edge.
        we = 2'b01; waddr[0] = 5'd9; wdata[0] = 32'd77;
        raddr[0] = 5'd9; raddr[1] = 5'd9;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("bypass_x9", rdata_z[0], 32'd77);
        check("bypass_x9_nz", rdata_nz[1], 32'd77);
        rst = 1'b1;
        #1;
        check("bypass_rst", rdata_z[0], 32'd0);
        rst = 1'b0;
        we = 2'b11; waddr[0] = 5'd0; wdata[0] = 32'hAA; waddr[1] = 5'd0; wdata[1] = 32'hBB;
        raddr[0] = 5'd0;
        #1;
        check("bypass_x0_z", rdata_z[0], 32'd0);
        check("bypass_x0_nz", rdata_nz[0], 32'hBB);
        we = '0;
`else
        check("old_x9", rdata_z[0], 32'd0);
        check("old_x9_nz", rdata_nz[1], 32'd0);
        we = '0;
`endif
        clock_edge();

        for (int i = 0; i < 300; i++) begin
            we = 2'($urandom_range(0, 3));
            waddr[0] = 5'($urandom_range(0, 31));
            waddr[1] = ($urandom_range(0, 3) == 0) ? waddr[0] : 5'($urandom_range(0, 31));
            wdata[0] = $urandom;
            wdata[1] = $urandom;
            rst = ($urandom_range(0, 39) == 0);
            read_model("rand_pre", waddr[$urandom_range(0, 1)], 5'($urandom_range(0, 31)));
            clock_edge();
            we = '0;
            rst = 1'b0;
            read_model("rand_post", waddr[1], 5'($urandom_range(0, 31)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ariane_regfile.md
Name: ariane_regfile

Overview:
- Multi-port integer register file for the Ariane/CVA6 issue/commit path.
- 32 architectural registers, flip-flop based.
- Combinational (asynchronous) read ports and clocked write ports.
- Commit stage writes results; issue stage reads operands.

Parameters:
- NR_READ_PORTS, 2, number of independent read ports.
- NR_WRITE_PORTS, 2, number of independent write ports.
- DATA_WIDTH, 32, register width in bits.
- ZERO_REG_ZERO, 1, when 1 register x0 is hardwired to zero; when 0 x0 is an ordinary register.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  synchronous active-high reset.
- test_en_i  input  1  clock-gate disable for DFT; no functional effect in this flop implementation; must be accepted and ignored.
- raddr_i  input  NR_READ_PORTS x 5  read address per port.
- rdata_o  output  NR_READ_PORTS x DATA_WIDTH  read data per port.
- waddr_i  input  NR_WRITE_PORTS x 5  write address per port.
- wdata_i  input  NR_WRITE_PORTS x DATA_WIDTH  write data per port.
- we_i  input  NR_WRITE_PORTS  write enable per port.

Behaviour:
- Storage: 32 entries x DATA_WIDTH flops, mem[0..31].
- Reset: on a rising edge with rst_i=1, all 32 entries clear to 0. Reset has priority over all writes in that cycle.
- Write: on a rising edge with rst_i=0, for each port p with we_i[p]=1, mem[waddr_i[p]] <= wdata_i[p]. Data is visible on reads from the cycle after the edge (1-cycle write-to-read latency).
- Write conflict: if several enabled ports target the same address in one cycle, the highest-index port wins. Example: port 1 overrides port 0. No error is flagged.
- Distinct addresses: all enabled ports write in the same cycle.
- Read: rdata_o[r] = mem[raddr_i[r]], purely combinational, no clock latency.
  - Multiple read ports may read the same address simultaneously.
  - Read during a same-cycle write returns the old value unless REGFILE_BYPASS_EN is defined.
- x0 with ZERO_REG_ZERO=1: writes to address 0 are discarded; reads of address 0 return 0 always.
- x0 with ZERO_REG_ZERO=0: x0 behaves like any other entry.
- Reset mid-operation: any writes presented in the reset cycle are dropped; all reads return 0 from the next cycle.
- we_i=0 on all ports: state holds.
- No handshake, no backpressure, no state machine.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-to-read forwarding. If an enabled write port targets raddr_i[r] in the current cycle, rdata_o[r] returns that port's wdata_i combinationally.
  - Among several matching ports, the highest index wins, consistent with the write-conflict rule.
  - Forwarding to x0 is suppressed when ZERO_REG_ZERO=1.
  - Reset cycle: no forwarding.
- Undefined: reads return only the stored value; writes become visible the cycle after the clock edge.

Test Plan:
- Reset: assert rst_i 1 cycle, read all 32 addresses -> every rdata_o = 0.
- Dual write/read: port0 writes x1=924232, port1 writes x2=3432, 1 edge, raddr=(1,2) -> rdata_o=(924232,3432).
- Second pair: x13=100, x14=200, 1 edge, raddr=(13,14) -> (100,200); x1 and x2 still read 924232 and 3432.
- Conflict: port0 writes x5=1000, port1 writes x5=1234 in the same cycle, raddr=(5,5) -> (1234,1234).
- x0: write x0=0xDEAD on both ports -> read x0 = 0 (ZERO_REG_ZERO=1). With ZERO_REG_ZERO=0 -> x0 reads 0xDEAD after 1 edge.
- Gating and reset priority: we_i=0 with new waddr/wdata -> contents unchanged. Assert rst_i together with a write x7=55 -> x7 reads 0. With REGFILE_BYPASS_EN: write x9=77 and read x9 in the same cycle -> 77 before the edge.
